// File: rtl/fuzzy_1.sv
// fuzzy_1: two-input interval type-2 fuzzy controller core.
// Fuzzifies two 8-bit crisp inputs against three FOU sets each, evaluates the
// 3x3 rule base one rule per cycle, aggregates upper/lower firing strengths per
// output set and defuzzifies by weighted centroid with a restoring divider.
module fuzzy_1 (
    input  logic       clk_0,
    input  logic       Srst,
    input  logic [7:0] Entrada_01,
    input  logic [7:0] Entrada_02,
    input  logic       EN_REGRAS,
    output logic [5:0] FOU_ATIVO,
    output logic [7:0] saida_defuzzy
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SAMPLE = 3'd1,
        ST_RULES  = 3'd2,
        ST_SUM    = 3'd3,
        ST_DIV    = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Upper membership grade of x in set (0 Low, 1 Med, 2 High), saturated to 0..255.
    function automatic logic [7:0] mf_upper(input logic [7:0] x, input logic [1:0] set);
        logic signed [11:0] d;
        logic signed [11:0] t;
        d = $signed({4'b0000, x}) - 12'sd128;
        case (set)
            2'd0:    t = -(d * 12'sd4);
            2'd1:    t = 12'sd256 - (((d < 12'sd0) ? -d : d) * 12'sd4);
            2'd2:    t = d * 12'sd4;
            default: t = 12'sd0;
        endcase
        if (t < 12'sd0) begin
            return 8'd0;
        end else if (t > 12'sd255) begin
            return 8'd255;
        end else begin
            return t[7:0];
        end
    endfunction

    // Lower membership grade: the upper grade pulled down by the FOU width of 64.
    function automatic logic [7:0] mf_lower(input logic [7:0] u);
        if (u >= 8'd64) begin
            return u - 8'd64;
        end else begin
            return 8'd0;
        end
    endfunction

    state_t          state_r;
    logic [7:0]      in1_r;
    logic [7:0]      in2_r;
    logic [3:0]      rule_r;
    logic [2:0][7:0] agg_up_r;
    logic [2:0][7:0] agg_low_r;
    logic [19:0]     rem_r;
    logic [10:0]     den_r;
    logic [7:0]      quo_r;
    logic [2:0]      div_cnt_r;

    logic [1:0]  set1_s;
    logic [1:0]  set2_s;
    logic [2:0]  ij_sum_s;
    logic [1:0]  cons_s;
    logic [7:0]  u1_s;
    logic [7:0]  u2_s;
    logic [7:0]  rule_up_s;
    logic [7:0]  rule_low_s;
    logic [5:0]  fou_s;
    logic [8:0]  w0_s;
    logic [8:0]  w1_s;
    logic [8:0]  w2_s;
    logic [19:0] num_s;
    logic [10:0] den_s;
    logic [17:0] dsh_s;
    logic        ge_s;

    // Decode the current rule into its antecedent sets, consequent and firing strengths.
    always_comb begin
        set1_s = 2'd0;
        set2_s = 2'd0;
        case (rule_r)
            4'd0:    begin set1_s = 2'd0; set2_s = 2'd0; end
            4'd1:    begin set1_s = 2'd0; set2_s = 2'd1; end
            4'd2:    begin set1_s = 2'd0; set2_s = 2'd2; end
            4'd3:    begin set1_s = 2'd1; set2_s = 2'd0; end
            4'd4:    begin set1_s = 2'd1; set2_s = 2'd1; end
            4'd5:    begin set1_s = 2'd1; set2_s = 2'd2; end
            4'd6:    begin set1_s = 2'd2; set2_s = 2'd0; end
            4'd7:    begin set1_s = 2'd2; set2_s = 2'd1; end
            4'd8:    begin set1_s = 2'd2; set2_s = 2'd2; end
            default: begin set1_s = 2'd0; set2_s = 2'd0; end
        endcase
        ij_sum_s = {1'b0, set1_s} + {1'b0, set2_s};
        if (ij_sum_s <= 3'd1) begin
            cons_s = 2'd0;
        end else if (ij_sum_s == 3'd2) begin
            cons_s = 2'd1;
        end else begin
            cons_s = 2'd2;
        end
        u1_s = mf_upper(in1_r, set1_s);
        u2_s = mf_upper(in2_r, set2_s);
        rule_up_s  = (u1_s < u2_s) ? u1_s : u2_s;
        rule_low_s = (mf_lower(u1_s) < mf_lower(u2_s)) ? mf_lower(u1_s) : mf_lower(u2_s);
    end

    // Active-FOU flags straight from the live inputs, captured only in SAMPLE.
    always_comb begin
        fou_s[0] = (mf_upper(Entrada_01, 2'd0) != 8'd0);
        fou_s[1] = (mf_upper(Entrada_01, 2'd1) != 8'd0);
        fou_s[2] = (mf_upper(Entrada_01, 2'd2) != 8'd0);
        fou_s[3] = (mf_upper(Entrada_02, 2'd0) != 8'd0);
        fou_s[4] = (mf_upper(Entrada_02, 2'd1) != 8'd0);
        fou_s[5] = (mf_upper(Entrada_02, 2'd2) != 8'd0);
    end

    // Centroid weights, numerator and denominator from the aggregated strengths.
    always_comb begin
        w0_s  = {1'b0, agg_up_r[0]} + {1'b0, agg_low_r[0]};
        w1_s  = {1'b0, agg_up_r[1]} + {1'b0, agg_low_r[1]};
        w2_s  = {1'b0, agg_up_r[2]} + {1'b0, agg_low_r[2]};
        num_s = ({11'd0, w0_s} << 5) + ({11'd0, w1_s} << 7) + ({11'd0, w2_s} * 20'd224);
        den_s = {2'b00, w0_s} + {2'b00, w1_s} + {2'b00, w2_s};
    end

    // Restoring-divider step: try to subtract den scaled to the current quotient bit.
    always_comb begin
        dsh_s = {7'd0, den_r} << (3'd7 - div_cnt_r);
        ge_s  = (rem_r >= {2'b00, dsh_s});
    end

    // Controller FSM with all datapath registers and registered outputs.
    always_ff @(posedge clk_0 or negedge Srst) begin
        if (!Srst) begin
            state_r       <= ST_IDLE;
            in1_r         <= 8'd0;
            in2_r         <= 8'd0;
            rule_r        <= 4'd0;
            agg_up_r      <= '0;
            agg_low_r     <= '0;
            rem_r         <= 20'd0;
            den_r         <= 11'd0;
            quo_r         <= 8'd0;
            div_cnt_r     <= 3'd0;
            FOU_ATIVO     <= 6'd0;
            saida_defuzzy <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (EN_REGRAS) begin
                        state_r <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    in1_r     <= Entrada_01;
                    in2_r     <= Entrada_02;
                    FOU_ATIVO <= fou_s;
                    agg_up_r  <= '0;
                    agg_low_r <= '0;
                    rule_r    <= 4'd0;
                    state_r   <= ST_RULES;
                end
                ST_RULES: begin
                    if (rule_up_s > agg_up_r[cons_s]) begin
                        agg_up_r[cons_s] <= rule_up_s;
                    end
                    if (rule_low_s > agg_low_r[cons_s]) begin
                        agg_low_r[cons_s] <= rule_low_s;
                    end
                    if (rule_r == 4'd8) begin
                        rule_r  <= 4'd0;
                        state_r <= ST_SUM;
                    end else begin
                        rule_r <= rule_r + 4'd1;
                    end
                end
                ST_SUM: begin
                    rem_r     <= num_s;
                    den_r     <= den_s;
                    quo_r     <= 8'd0;
                    div_cnt_r <= 3'd0;
                    state_r   <= ST_DIV;
                end
                ST_DIV: begin
                    if (ge_s) begin
                        rem_r <= rem_r - {2'b00, dsh_s};
                    end
                    quo_r <= {quo_r[6:0], ge_s};
                    if (div_cnt_r == 3'd7) begin
                        div_cnt_r <= 3'd0;
                        state_r   <= ST_DONE;
                    end else begin
                        div_cnt_r <= div_cnt_r + 3'd1;
                    end
                end
                ST_DONE: begin
                    saida_defuzzy <= (den_r == 11'd0) ? 8'd128 : quo_r;
                    state_r       <= EN_REGRAS ? ST_SAMPLE : ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fuzzy_1.sv
// tb_fuzzy_1: directed and randomized checks of fuzzy_1 against an arithmetic
// reference model of the fuzzy inference rules.
module tb_fuzzy_1;

    logic       clk_0;
    logic       Srst;
    logic [7:0] Entrada_01;
    logic [7:0] Entrada_02;
    logic       EN_REGRAS;
    logic [5:0] FOU_ATIVO;
    logic [7:0] saida_defuzzy;

    int errors = 0;
    int checks = 0;

    fuzzy_1 dut (
        .clk_0         (clk_0),
        .Srst          (Srst),
        .Entrada_01    (Entrada_01),
        .Entrada_02    (Entrada_02),
        .EN_REGRAS     (EN_REGRAS),
        .FOU_ATIVO     (FOU_ATIVO),
        .saida_defuzzy (saida_defuzzy)
    );

    // Free-running clock.
    initial begin
        clk_0 = 1'b0;
        forever #5 clk_0 = ~clk_0;
    end

    // Upper grade from the membership formulas, clamped to 0..255.
    function automatic int mu_u(input int x, input int s);
        int t;
        if (s == 0)      t = 4 * (128 - x);
        else if (s == 1) t = 256 - 4 * ((x >= 128) ? (x - 128) : (128 - x));
        else             t = 4 * (x - 128);
        if (t < 0)   t = 0;
        if (t > 255) t = 255;
        return t;
    endfunction

    function automatic int mu_l(input int u);
        return (u > 64) ? (u - 64) : 0;
    endfunction

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int model_out(input int a, input int b);
        int up[3];
        int lo[3];
        int cen[3];
        int num, den, k, u, l, w;
        cen[0] = 32; cen[1] = 128; cen[2] = 224;
        for (int k0 = 0; k0 < 3; k0++) begin up[k0] = 0; lo[k0] = 0; end
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                k = (i + j <= 1) ? 0 : ((i + j == 2) ? 1 : 2);
                u = min2(mu_u(a, i), mu_u(b, j));
                l = min2(mu_l(mu_u(a, i)), mu_l(mu_u(b, j)));
                if (u > up[k]) up[k] = u;
                if (l > lo[k]) lo[k] = l;
            end
        end
        num = 0; den = 0;
        for (int k1 = 0; k1 < 3; k1++) begin
            w = up[k1] + lo[k1];
            num += w * cen[k1];
            den += w;
        end
        return (den == 0) ? 128 : num / den;
    endfunction

    function automatic int model_fou(input int a, input int b);
        int f;
        f = 0;
        for (int s = 0; s < 3; s++) begin
            if (mu_u(a, s) > 0) f |= (1 << s);
            if (mu_u(b, s) > 0) f |= (1 << (s + 3));
        end
        return f;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One full evaluation; called just after the edge that entered SAMPLE.
    task automatic do_eval(input int a, input int b, input string tag);
        #1;
        Entrada_01 = 8'(a);
        Entrada_02 = 8'(b);
        @(posedge clk_0);
        #1;
        check({tag, "_fou"}, int'(FOU_ATIVO), model_fou(a, b));
        repeat (19) @(posedge clk_0);
        #1;
        check({tag, "_out"}, int'(saida_defuzzy), model_out(a, b));
    endtask

    // Hard time limit so the run always ends.
    initial begin
        #300000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    // Directed sequence followed by randomized evaluations.
    initial begin
        int a, b, exp_hold, fou_hold;
        Srst       = 1'b0;
        EN_REGRAS  = 1'b1;
        Entrada_01 = 8'd1;
        Entrada_02 = 8'd1;
        repeat (3) @(posedge clk_0);
        #1;
        check("reset_fou", int'(FOU_ATIVO), 0);
        check("reset_out", int'(saida_defuzzy), 0);
        Srst = 1'b1;
        @(posedge clk_0);

        do_eval(1, 1, "lowlow");
        check("lowlow_const_fou", int'(FOU_ATIVO), 6'b001001);
        check("lowlow_const_out", int'(saida_defuzzy), 32);
        do_eval(128, 128, "medmed");
        check("medmed_const_out", int'(saida_defuzzy), 128);
        do_eval(254, 254, "highhigh");
        check("highhigh_const_out", int'(saida_defuzzy), 224);
        do_eval(1, 254, "lowhigh");
        check("lowhigh_const_fou", int'(FOU_ATIVO), 6'b100001);
        do_eval(96, 128, "mixed");
        check("mixed_const_out", int'(saida_defuzzy), 80);
        do_eval(0, 255, "extremes");

        // Inputs changed mid-evaluation must not affect the running result.
        #1;
        Entrada_01 = 8'd200;
        Entrada_02 = 8'd60;
        @(posedge clk_0);
        #1;
        check("chg_fou", int'(FOU_ATIVO), model_fou(200, 60));
        repeat (5) @(posedge clk_0);
        #1;
        Entrada_01 = 8'd10;
        Entrada_02 = 8'd250;
        repeat (14) @(posedge clk_0);
        #1;
        check("chg_out", int'(saida_defuzzy), model_out(200, 60));

        // Randomized evaluations against the model.
        for (int n = 0; n < 16; n++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            do_eval(a, b, "rand");
        end

        // Asynchronous reset in the middle of DIV clears both outputs at once.
        #1;
        Entrada_01 = 8'd40;
        Entrada_02 = 8'd180;
        @(posedge clk_0);
        repeat (13) @(posedge clk_0);
        #1;
        Srst = 1'b0;
        #1;
        check("rst_div_fou", int'(FOU_ATIVO), 0);
        check("rst_div_out", int'(saida_defuzzy), 0);
        @(posedge clk_0);
        #1;
        Srst = 1'b1;
        @(posedge clk_0);
        do_eval(150, 100, "after_rst");

        // Drop EN_REGRAS mid-RULES: one final update, then everything holds.
        #1;
        Entrada_01 = 8'd96;
        Entrada_02 = 8'd128;
        @(posedge clk_0);
        repeat (4) @(posedge clk_0);
        #1;
        EN_REGRAS = 1'b0;
        Entrada_01 = 8'd254;
        Entrada_02 = 8'd254;
        repeat (15) @(posedge clk_0);
        #1;
        exp_hold = model_out(96, 128);
        fou_hold = model_fou(96, 128);
        check("endrop_out", int'(saida_defuzzy), exp_hold);
        check("endrop_fou", int'(FOU_ATIVO), fou_hold);
        repeat (45) @(posedge clk_0);
        #1;
        check("hold_out", int'(saida_defuzzy), exp_hold);
        check("hold_fou", int'(FOU_ATIVO), fou_hold);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
